// File: rtl/intt_butterfly_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : intt_butterfly_seq
// Description : Sequencer and coefficient buffer for an external combinational
//               INTT processing element. Loads LEN residues, runs LOGLEN
//               Gentleman-Sande stages in place (two PE operations per
//               butterfly) and streams the finished block out.
//               Optional macro INTT_SCALE_EN adds a final LEN^-1 scaling pass.
// Revision    : 1.0 - initial release
// ============================================================================
module intt_butterfly_seq #(
    parameter int N      = 9,
    parameter int LOGLEN = 3,
    parameter int NINV   = 225
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [N-1:0]      pe_a,
    output logic [N-1:0]      pe_b,
    output logic [N-1:0]      pe_c,
    output logic              pe_sub,
    input  logic [N-1:0]      pe_s,
    output logic [LOGLEN-2:0] tw_addr,
    input  logic [N-1:0]      tw_data,
    output logic              busy
);

    localparam int              LEN    = 1 << LOGLEN;
    localparam logic [N-1:0]    C_NINV = N'(NINV);
    localparam logic [N-1:0]    C_ONE  = N'(1);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_OP0  = 3'd1,
        S_OP1  = 3'd2,
        S_OUT  = 3'd3
`ifdef INTT_SCALE_EN
        ,
        S_SCALE = 3'd4
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [LOGLEN-1:0]   cnt_q, cnt_d;     // load / scale / output index
    logic [LOGLEN-1:0]   st_q, st_d;       // current stage
    logic [LOGLEN-1:0]   i_q, i_d;         // butterfly upper index

    logic [N-1:0]        buf_q [LEN];
    logic [N-1:0]        ha_q, hb_q;

    // Buffer and hold-register write controls produced by the FSM
    logic                buf_we;
    logic [LOGLEN-1:0]   buf_waddr;
    logic [N-1:0]        buf_wdata;
    logic                hold_we;

    // Butterfly index arithmetic for the current stage
    logic [LOGLEN-1:0]   w_half;
    logic [LOGLEN-1:0]   w_p;
    logic [LOGLEN-1:0]   w_j;
    logic [LOGLEN-1:0]   w_sh;
    logic [LOGLEN-1:0]   w_tw_full;
    logic [LOGLEN-1:0]   w_i_inc;
    logic [LOGLEN-1:0]   w_i_next;
    logic                w_last_i;
    logic                w_last_st;
    logic                w_last_cnt;

`ifndef INTT_SCALE_EN
    // NINV only matters when the scaling pass is built in
    logic                w_unused_ninv;
    assign w_unused_ninv = ^C_NINV;
`endif

    assign w_half     = LOGLEN'(1) << st_q;
    assign w_p        = i_q | w_half;
    assign w_j        = i_q & (w_half - LOGLEN'(1));
    assign w_sh       = LOGLEN'(LOGLEN - 1) - st_q;
    assign w_tw_full  = w_j << w_sh;
    // Skip over indices whose stage bit is set: the carry into bit st is
    // pushed past it by adding half once more.
    assign w_i_inc    = i_q + LOGLEN'(1);
    assign w_i_next   = ((w_i_inc & w_half) != '0) ? (w_i_inc + w_half) : w_i_inc;
    assign w_last_i   = &w_p;
    assign w_last_st  = (st_q == LOGLEN'(LOGLEN - 1));
    assign w_last_cnt = &cnt_q;

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_LOAD);
    assign out_data  = buf_q[cnt_q];

    // State, counters and indices; the only registers that take reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            st_q    <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            i_q     <= i_d;
        end
    end

    // Coefficient buffer and butterfly hold registers (contents survive reset)
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[buf_waddr] <= buf_wdata;
        end
        if (hold_we) begin
            ha_q <= buf_q[i_q];
            hb_q <= buf_q[w_p];
        end
    end

    // Next-state, PE operand drive and buffer write selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        st_d      = st_q;
        i_d       = i_q;
        pe_a      = '0;
        pe_b      = '0;
        pe_c      = '0;
        pe_sub    = 1'b0;
        tw_addr   = '0;
        buf_we    = 1'b0;
        buf_waddr = '0;
        buf_wdata = '0;
        hold_we   = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    buf_we    = 1'b1;
                    buf_waddr = cnt_q;
                    buf_wdata = in_data;
                    if (w_last_cnt) begin
                        cnt_d   = '0;
                        st_d    = '0;
                        i_d     = '0;
                        state_d = S_OP0;
                    end else begin
                        cnt_d = cnt_q + LOGLEN'(1);
                    end
                end
            end

            S_OP0: begin
                // Sum half of the butterfly: buf[i] <- buf[i] + buf[p]
                pe_a      = buf_q[i_q];
                pe_b      = buf_q[w_p];
                pe_c      = C_ONE;
                tw_addr   = w_tw_full[LOGLEN-2:0];
                buf_we    = 1'b1;
                buf_waddr = i_q;
                buf_wdata = pe_s;
                hold_we   = 1'b1;
                state_d   = S_OP1;
            end

            S_OP1: begin
                // Difference half from the held originals: buf[p] <- (a-b)*w
                pe_a      = ha_q;
                pe_b      = hb_q;
                pe_c      = tw_data;
                pe_sub    = 1'b1;
                tw_addr   = w_tw_full[LOGLEN-2:0];
                buf_we    = 1'b1;
                buf_waddr = w_p;
                buf_wdata = pe_s;
                if (w_last_i) begin
                    i_d = '0;
                    if (w_last_st) begin
                        st_d  = '0;
                        cnt_d = '0;
`ifdef INTT_SCALE_EN
                        state_d = S_SCALE;
`else
                        state_d = S_OUT;
`endif
                    end else begin
                        st_d    = st_q + LOGLEN'(1);
                        state_d = S_OP0;
                    end
                end else begin
                    i_d     = w_i_next;
                    state_d = S_OP0;
                end
            end

`ifdef INTT_SCALE_EN
            S_SCALE: begin
                pe_a      = buf_q[cnt_q];
                pe_b      = '0;
                pe_c      = C_NINV;
                buf_we    = 1'b1;
                buf_waddr = cnt_q;
                buf_wdata = pe_s;
                if (w_last_cnt) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + LOGLEN'(1);
                end
            end
`endif

            S_OUT: begin
                if (out_ready) begin
                    if (w_last_cnt) begin
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q + LOGLEN'(1);
                    end
                end
            end

            default: begin
                state_d = S_LOAD;
                cnt_d   = '0;
                st_d    = '0;
                i_d     = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_intt_butterfly_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_intt_butterfly_seq
// Description : Directed bench for intt_butterfly_seq with a modular PE model
//               and an all-ones twiddle ROM (Walsh-Hadamard mod 257).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intt_butterfly_seq;

    localparam int N   = 9;
    localparam int LEN = 8;
`ifdef INTT_SCALE_EN
    localparam int LAT = 32;
    localparam int ONE = 225;   // 1 * 8^-1 mod 257
    localparam int NEG = 32;    // 256 * 8^-1 mod 257
    localparam int CST = 1;     // 8 * 8^-1
    localparam int E8  = 1;     // 8 * 225 mod 257
    localparam int E2N = 64;    // 255 * 225 mod 257
`else
    localparam int LAT = 24;
    localparam int ONE = 1;
    localparam int NEG = 256;
    localparam int CST = 8;
    localparam int E8  = 8;
    localparam int E2N = 255;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [N-1:0] pe_a, pe_b, pe_c, pe_s;
    logic         pe_sub;
    logic [1:0]   tw_addr;
    logic [N-1:0] tw_data;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [7:0][N-1:0] din;
        logic [7:0][N-1:0] dexp;
    } vec_t;

    vec_t vecs [5];

    intt_butterfly_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pe_a      (pe_a),
        .pe_b      (pe_b),
        .pe_c      (pe_c),
        .pe_sub    (pe_sub),
        .pe_s      (pe_s),
        .tw_addr   (tw_addr),
        .tw_data   (tw_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference PE: ((a +/- b) mod 257) * c mod 257
    function automatic logic [N-1:0] pe_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] c, input logic sub);
        int t;
        t = sub ? ((int'(a) - int'(b) + 257) % 257) : ((int'(a) + int'(b)) % 257);
        return N'((t * int'(c)) % 257);
    endfunction

    always_comb pe_s = pe_f(pe_a, pe_b, pe_c, pe_sub);
    assign tw_data = N'(1);

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_block(input logic [7:0][N-1:0] d, output int t_last);
        for (int k = 0; k < LEN; k++) begin
            in_valid = 1'b1;
            in_data  = d[k];
            if (!in_ready) chk($sformatf("load_ready[%0d]", k), 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        t_last   = cyc;
        chk("busy_after_load", int'(busy), 1);
        chk("in_ready_after_load", int'(in_ready), 0);
    endtask

    // Hammer in_valid with junk during compute and measure edges to out_valid
    task automatic run_compute(input int t_last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = N'(99);
        while (!out_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("latency", cyc - t_last, LAT);
    endtask

    task automatic read_block(input logic [7:0][N-1:0] e, input bit bp, input string nm);
        int idx;
        int ph;
        idx = 0;
        ph  = 0;
        while (idx < LEN && ph < 200) begin
            out_ready = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            if (out_valid) begin
                chk($sformatf("%s[%0d]", nm, idx), int'(out_data), int'(e[idx]));
                if (out_ready) idx++;
            end
            @(posedge clk); #1;
            ph++;
        end
        out_ready = 1'b0;
        chk($sformatf("%s_words", nm), idx, LEN);
        chk($sformatf("%s_in_ready", nm), int'(in_ready), 1);
        chk($sformatf("%s_out_valid", nm), int'(out_valid), 0);
        chk($sformatf("%s_busy", nm), int'(busy), 0);
    endtask

    task automatic idle_checks(input string nm);
        chk({nm, "_in_ready"}, int'(in_ready), 1);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_pe_a"}, int'(pe_a), 0);
        chk({nm, "_pe_b"}, int'(pe_b), 0);
        chk({nm, "_pe_c"}, int'(pe_c), 0);
        chk({nm, "_pe_sub"}, int'(pe_sub), 0);
        chk({nm, "_tw_addr"}, int'(tw_addr), 0);
    endtask

    initial begin
        int t;
        // Vector table: impulse, subtraction wrap, constant, last-index impulse, mixed
        for (int v = 0; v < 5; v++) begin
            vecs[v].din  = '0;
            vecs[v].dexp = '0;
        end
        for (int k = 0; k < LEN; k++) begin
            vecs[0].dexp[k] = N'(ONE);
            vecs[1].dexp[k] = N'((k % 2 == 1) ? NEG : ONE);
            vecs[2].din[k]  = N'(1);
            vecs[3].dexp[k] = N'(($countones(k) % 2 == 1) ? NEG : ONE);
            vecs[4].dexp[k] = N'((k % 2 == 1) ? E2N : E8);
        end
        vecs[0].din[0]  = N'(1);
        vecs[1].din[1]  = N'(1);
        vecs[2].dexp[0] = N'(CST);
        vecs[3].din[7]  = N'(1);
        vecs[4].din[0]  = N'(3);
        vecs[4].din[1]  = N'(5);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle_checks("reset");
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            load_block(vecs[v].din, t);
            run_compute(t);
            read_block(vecs[v].dexp, (v % 2 == 1), $sformatf("vec%0d", v));
        end

        // Reset during the 10th compute cycle discards the block
        load_block(vecs[2].din, t);
        in_valid = 1'b1;
        in_data  = N'(99);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle_checks("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_hold_out_valid", int'(out_valid), 0);
        chk("midrst_hold_in_ready", int'(in_ready), 1);

        // A fresh impulse after the aborted block must come out clean
        load_block(vecs[0].din, t);
        run_compute(t);
        read_block(vecs[0].dexp, 1'b1, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
